// File: rtl/serializer_core_scheduler.sv
// Per-core task lifecycle tracker in front of the conflict serializer.
// Gates dequeue requests with an anti-starvation mask and funnels
// simultaneous core finishes into a single round-robin finish port.
module serializer_core_scheduler #(
    parameter int NUM_CORES       = 16,
    parameter int TASK_TYPE_WIDTH = 4,
    parameter int STARVE_LIMIT    = 64,
    localparam int LOG_N          = $clog2(NUM_CORES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CORES-1:0]                 core_req_valid,
    input  logic [NUM_CORES*TASK_TYPE_WIDTH-1:0] core_req_ttype,
    input  logic [NUM_CORES-1:0]                 core_finish,
    output logic [NUM_CORES-1:0]                 core_grant,
    output logic [NUM_CORES-1:0]                 s_arvalid,
    output logic [NUM_CORES*TASK_TYPE_WIDTH-1:0] s_araddr,
    input  logic [NUM_CORES-1:0]                 s_rvalid,
    output logic                                 finished_task_valid,
    output logic [LOG_N-1:0]                     finished_task_core,
    output logic                                 all_idle,
    output logic [31:0]                          starve_count,
    output logic                                 protocol_err
);

    localparam int unsigned NC          = NUM_CORES;
    localparam int unsigned TW          = TASK_TYPE_WIDTH;
    localparam logic [7:0]  STARVE_LIM8 = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT, RUN, FIN} core_state_e;

    core_state_e            state_q [NUM_CORES];
    core_state_e            state_d [NUM_CORES];
    logic [7:0]             age_q   [NUM_CORES];
    logic [NUM_CORES-1:0]   mask_q;
    logic                   prio_held;
    logic [LOG_N-1:0]       prio_idx;
    logic [LOG_N-1:0]       rr_ptr;
    logic                   win_found;
    logic [LOG_N-1:0]       win_idx;
    logic                   starve_found;
    logic [LOG_N-1:0]       starve_idx;
    logic [NUM_CORES-1:0]   run_vec;
    int unsigned            rr_idx;

    // Round-robin pick of the first FIN core at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        for (int unsigned k = 0; k < NC; k++) begin
            rr_idx = 32'(rr_ptr) + k;
            if (rr_idx >= NC) rr_idx = rr_idx - NC;
            if (!win_found && state_q[rr_idx[LOG_N-1:0]] == FIN) begin
                win_found = 1'b1;
                win_idx   = rr_idx[LOG_N-1:0];
            end
        end
    end

    // Lowest-index waiting core whose age has reached the starvation limit.
    always_comb begin
        starve_found = 1'b0;
        starve_idx   = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (!starve_found && state_q[i] == WAIT && age_q[i] >= STARVE_LIM8) begin
                starve_found = 1'b1;
                starve_idx   = LOG_N'(i);
            end
        end
    end

    // Per-core next-state logic.
    always_comb begin
        for (int unsigned i = 0; i < NC; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (core_req_valid[i]) state_d[i] = WAIT;
                WAIT:    if (s_rvalid[i])       state_d[i] = RUN;
                RUN:     if (core_finish[i])    state_d[i] = FIN;
                FIN:     if (win_found && win_idx == LOG_N'(i)) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Combinational outputs decoded from the state vector.
    always_comb begin
        core_grant = '0;
        s_arvalid  = '0;
        run_vec    = '0;
        all_idle   = 1'b1;
        for (int unsigned i = 0; i < NC; i++) begin
            core_grant[i] = s_rvalid[i] && state_q[i] == WAIT;
            s_arvalid[i]  = mask_q[i] && state_q[i] == WAIT;
            run_vec[i]    = state_q[i] == RUN;
            if (state_q[i] != IDLE) all_idle = 1'b0;
        end
    end

    // Per-core state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NC; i++) state_q[i] <= IDLE;
        end else begin
            for (int unsigned i = 0; i < NC; i++) state_q[i] <= state_d[i];
        end
    end

    // Capture requested type on acceptance; age waiting cores with saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_araddr <= '0;
            for (int unsigned i = 0; i < NC; i++) age_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NC; i++) begin
                if (state_q[i] == IDLE && core_req_valid[i]) begin
                    s_araddr[i*TW +: TW] <= core_req_ttype[i*TW +: TW];
                    age_q[i]             <= '0;
                end else if (state_q[i] == WAIT && age_q[i] != 8'hFF) begin
                    age_q[i] <= age_q[i] + 8'd1;
                end
            end
        end
    end

    // Anti-starvation mask: hold one starved core exclusive until it is served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q       <= '1;
            prio_held    <= 1'b0;
            prio_idx     <= '0;
            starve_count <= '0;
        end else if (prio_held) begin
            if (s_rvalid[prio_idx] && state_q[prio_idx] == WAIT) begin
                prio_held <= 1'b0;
                mask_q    <= '1;
            end
        end else if (starve_found) begin
            prio_held <= 1'b1;
            prio_idx  <= starve_idx;
            mask_q    <= {{(NUM_CORES-1){1'b0}}, 1'b1} << starve_idx;
            if (starve_count != '1) starve_count <= starve_count + 32'd1;
        end
    end

    // Registered finish notification, round-robin pointer and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finished_task_valid <= 1'b0;
            finished_task_core  <= '0;
            rr_ptr              <= '0;
            protocol_err        <= 1'b0;
        end else begin
            finished_task_valid <= win_found;
            if (win_found) begin
                finished_task_core <= win_idx;
                rr_ptr <= (win_idx == LOG_N'(NC - 1)) ? '0 : win_idx + 1'b1;
            end
            if (|(core_finish & ~run_vec)) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serializer_core_scheduler.sv
// Self-checking bench for serializer_core_scheduler: table-driven lifecycle
// vectors, hand-written multi-cycle sequences, and a finish-order scoreboard.
module tb_serializer_core_scheduler;

    localparam int N  = 16;
    localparam int TW = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    core_req_valid;
    logic [N*TW-1:0] core_req_ttype;
    logic [N-1:0]    core_finish;
    logic [N-1:0]    core_grant;
    logic [N-1:0]    s_arvalid;
    logic [N*TW-1:0] s_araddr;
    logic [N-1:0]    s_rvalid;
    logic            finished_task_valid;
    logic [3:0]      finished_task_core;
    logic            all_idle;
    logic [31:0]     starve_count;
    logic            protocol_err;

    serializer_core_scheduler #(
        .NUM_CORES(N),
        .TASK_TYPE_WIDTH(TW),
        .STARVE_LIMIT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .core_req_valid(core_req_valid),
        .core_req_ttype(core_req_ttype),
        .core_finish(core_finish),
        .core_grant(core_grant),
        .s_arvalid(s_arvalid),
        .s_araddr(s_araddr),
        .s_rvalid(s_rvalid),
        .finished_task_valid(finished_task_valid),
        .finished_task_core(finished_task_core),
        .all_idle(all_idle),
        .starve_count(starve_count),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    typedef struct {
        logic [N-1:0]    req;
        logic [N*TW-1:0] ttype;
        logic [N-1:0]    rv;
        logic [N-1:0]    fin;
        logic [N-1:0]    exp_arv;
        logic [N-1:0]    exp_grant;
        logic [N*TW-1:0] exp_addr;
        logic            exp_idle;
        logic            push;
        int              fin_core;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        core_req_valid = '0;
        core_req_ttype = '0;
        core_finish    = '0;
        s_rvalid       = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: every finish notification must match the next expected core.
    always @(negedge clk) begin
        if (!rst && finished_task_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish: actual core=%0d required=none", finished_task_core);
            end else begin
                chk("finish_core", 64'(finished_task_core), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // req, ttype, rv, fin, exp_arv, exp_grant, exp_addr, exp_idle, push, fin_core
        tbl[0] = '{16'h0008, 64'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 64'h0000, 1'b1, 1'b0, 0};
        tbl[1] = '{16'h0000, 64'h0000, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 64'h2000, 1'b0, 1'b0, 0};
        tbl[2] = '{16'h0000, 64'h0000, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 64'h2000, 1'b0, 1'b0, 0};
        tbl[3] = '{16'h0000, 64'h0000, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 64'h2000, 1'b0, 1'b0, 0};
        tbl[4] = '{16'h0000, 64'h0000, 16'h0008, 16'h0000, 16'h0008, 16'h0008, 64'h2000, 1'b0, 1'b0, 0};
        tbl[5] = '{16'h0000, 64'h0000, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 64'h2000, 1'b0, 1'b0, 0};
        tbl[6] = '{16'h0000, 64'h0000, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 64'h2000, 1'b0, 1'b1, 3};
        tbl[7] = '{16'h0000, 64'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 64'h2000, 1'b0, 1'b0, 0};
        tbl[8] = '{16'h0008, 64'h5000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 64'h2000, 1'b1, 1'b0, 0};
        tbl[9] = '{16'h0000, 64'h0000, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 64'h5000, 1'b0, 1'b0, 0};

        do_reset();
        chk("reset_arvalid", 64'(s_arvalid), 64'h0);
        chk("reset_all_idle", 64'(all_idle), 64'h1);
        chk("reset_fin_valid", 64'(finished_task_valid), 64'h0);
        chk("reset_starve", 64'(starve_count), 64'h0);

        // Lifecycle of core 3 as a per-cycle vector table
        for (int r = 0; r < 10; r++) begin
            core_req_valid = tbl[r].req;
            core_req_ttype = tbl[r].ttype;
            s_rvalid       = tbl[r].rv;
            core_finish    = tbl[r].fin;
            if (tbl[r].push) exp_q.push_back(tbl[r].fin_core);
            #1;
            chk($sformatf("row%0d_arvalid", r), 64'(s_arvalid), 64'(tbl[r].exp_arv));
            chk($sformatf("row%0d_grant", r), 64'(core_grant), 64'(tbl[r].exp_grant));
            chk($sformatf("row%0d_araddr", r), s_araddr, tbl[r].exp_addr);
            chk($sformatf("row%0d_all_idle", r), 64'(all_idle), 64'(tbl[r].exp_idle));
            tick();
        end
        clear_in();
        chk("lifecycle_err", 64'(protocol_err), 64'h0);

        // Simultaneous finishes on cores 0, 5, 9 with rr_ptr = 0
        do_reset();
        core_req_valid = 16'h0221;
        tick();
        clear_in();
        s_rvalid = 16'h0221;
        tick();
        clear_in();
        core_finish = 16'h0221;
        exp_q.push_back(0);
        exp_q.push_back(5);
        exp_q.push_back(9);
        tick();
        clear_in();
        chk("rr_t1_valid", 64'(finished_task_valid), 64'h0);
        tick();
        chk("rr_t2_valid", 64'(finished_task_valid), 64'h1);
        tick();
        chk("rr_t3_valid", 64'(finished_task_valid), 64'h1);
        chk("rr_t3_idle", 64'(all_idle), 64'h0);
        tick();
        chk("rr_t4_valid", 64'(finished_task_valid), 64'h1);
        chk("rr_t4_idle", 64'(all_idle), 64'h1);
        tick();
        chk("rr_t5_valid", 64'(finished_task_valid), 64'h0);

        // rr_ptr now 10: cores 3 and 12 together must drain 12 first
        core_req_valid = 16'h1008;
        tick();
        clear_in();
        s_rvalid = 16'h1008;
        tick();
        clear_in();
        core_finish = 16'h1008;
        exp_q.push_back(12);
        exp_q.push_back(3);
        tick();
        clear_in();
        repeat (4) tick();
        chk("rr_wrap_drained", 64'(exp_q.size()), 64'h0);

        // Starvation: core 15 waits from E0, core 0 from E0+10, nobody served
        do_reset();
        core_req_valid = 16'h8000;
        tick();
        clear_in();
        repeat (9) tick();
        core_req_valid = 16'h0001;
        tick();
        clear_in();
        repeat (54) tick();
        chk("prio_age64_arvalid", 64'(s_arvalid), 64'h8001);
        chk("prio_age64_starve", 64'(starve_count), 64'h0);
        tick();
        chk("prio_mask_arvalid", 64'(s_arvalid), 64'h8000);
        chk("prio_mask_starve", 64'(starve_count), 64'h1);
        repeat (3) tick();
        chk("prio_held_arvalid", 64'(s_arvalid), 64'h8000);
        chk("prio_held_starve", 64'(starve_count), 64'h1);
        s_rvalid = 16'h8000;
        #1;
        chk("prio_grant15", 64'(core_grant), 64'h8000);
        tick();
        clear_in();
        chk("prio_exit_arvalid", 64'(s_arvalid), 64'h0001);
        s_rvalid = 16'h0001;
        tick();
        clear_in();
        chk("prio_done_arvalid", 64'(s_arvalid), 64'h0);
        chk("prio_done_starve", 64'(starve_count), 64'h1);

        // Core 4: finish and request in the same cycle while RUN
        do_reset();
        core_req_valid = 16'h0010;
        core_req_ttype = 64'h30000;
        tick();
        clear_in();
        s_rvalid = 16'h0010;
        tick();
        clear_in();
        core_finish    = 16'h0010;
        core_req_valid = 16'h0010;
        core_req_ttype = 64'hA0000;
        exp_q.push_back(4);
        tick();
        clear_in();
        chk("c4_fin_arvalid", 64'(s_arvalid), 64'h0);
        chk("c4_fin_araddr", s_araddr, 64'h30000);
        chk("c4_fin_idle", 64'(all_idle), 64'h0);
        repeat (2) tick();
        chk("c4_drained_idle", 64'(all_idle), 64'h1);
        chk("c4_drained_q", 64'(exp_q.size()), 64'h0);
        chk("c4_err", 64'(protocol_err), 64'h0);
        core_req_valid = 16'h0010;
        core_req_ttype = 64'h90000;
        tick();
        clear_in();
        chk("c4_rereq_arvalid", 64'(s_arvalid), 64'h0010);
        chk("c4_rereq_araddr", s_araddr, 64'h90000);

        // Illegal finish on idle core 2
        core_finish = 16'h0004;
        tick();
        clear_in();
        chk("err_set", 64'(protocol_err), 64'h1);
        chk("err_arvalid", 64'(s_arvalid), 64'h0010);
        repeat (3) tick();
        chk("err_sticky", 64'(protocol_err), 64'h1);

        // Async reset with WAIT cores, FIN pending and priority active
        core_req_valid = 16'h80C2;
        tick();
        clear_in();
        s_rvalid = 16'h00C0;
        tick();
        clear_in();
        repeat (70) tick();
        chk("mid_starve", 64'(starve_count), 64'h1);
        chk("mid_arvalid", 64'(s_arvalid), 64'h0010);
        core_finish = 16'h00C0;
        exp_q.push_back(6);
        exp_q.push_back(7);
        tick();
        clear_in();
        #2;
        s_rvalid = 16'h8012;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("ar_fin_valid", 64'(finished_task_valid), 64'h0);
        chk("ar_fin_core", 64'(finished_task_core), 64'h0);
        chk("ar_arvalid", 64'(s_arvalid), 64'h0);
        chk("ar_grant", 64'(core_grant), 64'h0);
        chk("ar_araddr", s_araddr, 64'h0);
        chk("ar_all_idle", 64'(all_idle), 64'h1);
        chk("ar_starve", 64'(starve_count), 64'h0);
        chk("ar_err", 64'(protocol_err), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_rvalid = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", c), 64'(finished_task_valid), 64'h0);
        end
        chk("post_rst_arvalid", 64'(s_arvalid), 64'h0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
